instruction_control_unit: RTL and testbench

- Hardwired Moore control sequencer that drives the datapath's control inputs: enables, selects, Gra/Grb/Grc, ba_select, read/write and alu_instruction.
- Sits directly upstream of the datapath. Consumes IR_Data and con_output; replaces hand-driven T-state stimulus.
- Sequences fetch (T0-T2) and per-opcode execute states (T3-T7) for the implemented subset, then loops back to fetch. Stops on halt.

---
 rtl/instruction_control_unit.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_instruction_control_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_control_unit.sv
// Hardwired Moore control sequencer: fetch T0-T2, per-opcode execute T3-T7, HALT until reset.
// Control outputs are registered from the next-state decode so they are glitch-free for the datapath.
module instruction_control_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IR_Data,
    input  logic        con_output,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        r_enable,
    output logic        con_enable,
    output logic        manual_R15_enable,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        ba_select,
    output logic        PC_select,
    output logic        Z_LO_select,
    output logic        MDR_select,
    output logic        c_select,
    output logic        r_select,
    output logic [4:0]  alu_instruction,
    output logic        run,
    output logic        instr_done
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned ALU_W = 5;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'b00001;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'b00010;
    localparam logic [ALU_W-1:0] ALU_AND = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'b00100;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic             pc_en;
        logic             pc_inc;
        logic             ir_en;
        logic             y_en;
        logic             z_en;
        logic             mar_en;
        logic             mdr_en;
        logic             r_en;
        logic             con_en;
        logic             r15_en;
        logic             rd;
        logic             wr;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             ba;
        logic             pc_sel;
        logic             zlo_sel;
        logic             mdr_sel;
        logic             c_sel;
        logic             r_sel;
        logic [ALU_W-1:0] alu;
        logic             run;
        logic             done;
    } ctl_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_opcode;
    logic [OP_W-1:0]   w_op_nxt;
    ctl_t              r_ctl;
    ctl_t              w_ctl;
    logic              w_unused_ir;

    // Register fields are consumed by the datapath's select/encode block, not here.
    assign w_unused_ir = ^IR_Data[26:0];

    // Opcode is latched as fetch completes; execute states use the latched copy.
    assign w_op_nxt = (r_state == S_T2) ? IR_Data[31:27] : r_opcode;

    // Next-state logic
    always_comb begin
        w_next = S_T0;
        case (r_state)
            S_IDLE: w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3: begin
                case (r_opcode)
                    OP_HALT: w_next = S_HALT;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                    OP_LDI, OP_LD, OP_ST, OP_BR, OP_JAL: w_next = S_T4;
                    default: w_next = S_T0;
                endcase
            end
            S_T4:   w_next = (r_opcode == OP_JAL) ? S_T0 : S_T5;
            S_T5: begin
                case (r_opcode)
                    OP_LD, OP_ST, OP_BR: w_next = S_T6;
                    default:             w_next = S_T0;
                endcase
            end
            S_T6:   w_next = (r_opcode == OP_BR) ? S_T0 : S_T7;
            S_T7:   w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_T0;
        endcase
    end

    // Control decode for the state being entered
    always_comb begin
        w_ctl = '0;
        case (w_next)
            S_T0: begin
                w_ctl.run     = 1'b1;
                w_ctl.pc_sel  = 1'b1;
                w_ctl.mar_en  = 1'b1;
            end
            S_T1: begin
                w_ctl.run     = 1'b1;
                w_ctl.pc_inc  = 1'b1;
                w_ctl.rd      = 1'b1;
                w_ctl.mdr_en  = 1'b1;
            end
            S_T2: begin
                w_ctl.run     = 1'b1;
                w_ctl.mdr_sel = 1'b1;
                w_ctl.ir_en   = 1'b1;
            end
            S_T3: begin
                w_ctl.run = 1'b1;
                case (w_op_nxt)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        w_ctl.grb   = 1'b1;
                        w_ctl.r_sel = 1'b1;
                        w_ctl.y_en  = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        w_ctl.grb  = 1'b1;
                        w_ctl.ba   = 1'b1;
                        w_ctl.y_en = 1'b1;
                    end
                    OP_BR: begin
                        w_ctl.gra    = 1'b1;
                        w_ctl.r_sel  = 1'b1;
                        w_ctl.con_en = 1'b1;
                    end
                    OP_JR: begin
                        w_ctl.gra   = 1'b1;
                        w_ctl.r_sel = 1'b1;
                        w_ctl.pc_en = 1'b1;
                        w_ctl.done  = 1'b1;
                    end
                    OP_JAL: begin
                        w_ctl.r15_en = 1'b1;
                        w_ctl.pc_sel = 1'b1;
                    end
                    OP_HALT: w_ctl.done = 1'b0;
                    default: w_ctl.done = 1'b1;
                endcase
            end
            S_T4: begin
                w_ctl.run = 1'b1;
                case (w_op_nxt)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        w_ctl.grc   = 1'b1;
                        w_ctl.r_sel = 1'b1;
                        w_ctl.z_en  = 1'b1;
                        case (w_op_nxt)
                            OP_SUB:  w_ctl.alu = ALU_SUB;
                            OP_AND:  w_ctl.alu = ALU_AND;
                            OP_OR:   w_ctl.alu = ALU_OR;
                            default: w_ctl.alu = ALU_ADD;
                        endcase
                    end
                    OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                        w_ctl.c_sel = 1'b1;
                        w_ctl.alu   = ALU_ADD;
                        w_ctl.z_en  = 1'b1;
                    end
                    OP_BR: begin
                        w_ctl.pc_sel = 1'b1;
                        w_ctl.y_en   = 1'b1;
                    end
                    OP_JAL: begin
                        w_ctl.gra   = 1'b1;
                        w_ctl.r_sel = 1'b1;
                        w_ctl.pc_en = 1'b1;
                        w_ctl.done  = 1'b1;
                    end
                    default: w_ctl.run = 1'b1;
                endcase
            end
            S_T5: begin
                w_ctl.run = 1'b1;
                case (w_op_nxt)
                    OP_LD, OP_ST: begin
                        w_ctl.zlo_sel = 1'b1;
                        w_ctl.mar_en  = 1'b1;
                    end
                    OP_BR: begin
                        w_ctl.c_sel = 1'b1;
                        w_ctl.alu   = ALU_ADD;
                        w_ctl.z_en  = 1'b1;
                    end
                    default: begin
                        w_ctl.zlo_sel = 1'b1;
                        w_ctl.gra     = 1'b1;
                        w_ctl.r_en    = 1'b1;
                        w_ctl.done    = 1'b1;
                    end
                endcase
            end
            S_T6: begin
                w_ctl.run = 1'b1;
                case (w_op_nxt)
                    OP_LD: begin
                        w_ctl.rd     = 1'b1;
                        w_ctl.mdr_en = 1'b1;
                    end
                    OP_ST: begin
                        w_ctl.gra    = 1'b1;
                        w_ctl.r_sel  = 1'b1;
                        w_ctl.mdr_en = 1'b1;
                    end
                    default: begin
                        // Branch commits Z to PC only when the condition flop is set.
                        w_ctl.done    = 1'b1;
                        w_ctl.zlo_sel = con_output;
                        w_ctl.pc_en   = con_output;
                    end
                endcase
            end
            S_T7: begin
                w_ctl.run  = 1'b1;
                w_ctl.done = 1'b1;
                if (w_op_nxt == OP_ST) begin
                    w_ctl.wr = 1'b1;
                end else begin
                    w_ctl.mdr_sel = 1'b1;
                    w_ctl.gra     = 1'b1;
                    w_ctl.r_en    = 1'b1;
                end
            end
            default: w_ctl = '0;
        endcase
    end

    // State, latched opcode and registered controls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_ctl    <= '0;
        end else begin
            r_state  <= w_next;
            r_opcode <= w_op_nxt;
            r_ctl    <= w_ctl;
        end
    end

    assign PC_enable           = r_ctl.pc_en;
    assign PC_increment_enable = r_ctl.pc_inc;
    assign IR_enable           = r_ctl.ir_en;
    assign Y_enable            = r_ctl.y_en;
    assign Z_enable            = r_ctl.z_en;
    assign MAR_enable          = r_ctl.mar_en;
    assign MDR_enable          = r_ctl.mdr_en;
    assign r_enable            = r_ctl.r_en;
    assign con_enable          = r_ctl.con_en;
    assign manual_R15_enable   = r_ctl.r15_en;
    assign read                = r_ctl.rd;
    assign write               = r_ctl.wr;
    assign Gra                 = r_ctl.gra;
    assign Grb                 = r_ctl.grb;
    assign Grc                 = r_ctl.grc;
    assign ba_select           = r_ctl.ba;
    assign PC_select           = r_ctl.pc_sel;
    assign Z_LO_select         = r_ctl.zlo_sel;
    assign MDR_select          = r_ctl.mdr_sel;
    assign c_select            = r_ctl.c_sel;
    assign r_select            = r_ctl.r_sel;
    assign alu_instruction     = r_ctl.alu;
    assign run                 = r_ctl.run;
    assign instr_done          = r_ctl.done;

endmodule

// File: tb/tb_instruction_control_unit.sv
// Scoreboard bench for instruction_control_unit: stimulus queues per-cycle expected
// control vectors, a negedge monitor pops and compares them against the DUT.
module tb_instruction_control_unit;

    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b00010;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_OR  = 5'b00100;

    typedef struct packed {
        logic       pc_en;
        logic       pc_inc;
        logic       ir_en;
        logic       y_en;
        logic       z_en;
        logic       mar_en;
        logic       mdr_en;
        logic       r_en;
        logic       con_en;
        logic       r15_en;
        logic       rd;
        logic       wr;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       ba;
        logic       pc_sel;
        logic       zlo_sel;
        logic       mdr_sel;
        logic       c_sel;
        logic       r_sel;
        logic [4:0] alu;
        logic       run;
        logic       done;
    } ctl_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] IR_Data;
    logic        con_output;
    logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic        MAR_enable, MDR_enable, r_enable, con_enable, manual_R15_enable;
    logic        read, write, Gra, Grb, Grc, ba_select;
    logic        PC_select, Z_LO_select, MDR_select, c_select, r_select;
    logic [4:0]  alu_instruction;
    logic        run, instr_done;

    int          errors = 0;
    int          checks = 0;
    ctl_t        q_exp[$];
    string       q_name[$];
    ctl_t        m_act;
    ctl_t        m_exp;
    string       m_name;

    instruction_control_unit dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .IR_Data             (IR_Data),
        .con_output          (con_output),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .r_enable            (r_enable),
        .con_enable          (con_enable),
        .manual_R15_enable   (manual_R15_enable),
        .read                (read),
        .write               (write),
        .Gra                 (Gra),
        .Grb                 (Grb),
        .Grc                 (Grc),
        .ba_select           (ba_select),
        .PC_select           (PC_select),
        .Z_LO_select         (Z_LO_select),
        .MDR_select          (MDR_select),
        .c_select            (c_select),
        .r_select            (r_select),
        .alu_instruction     (alu_instruction),
        .run                 (run),
        .instr_done          (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", q_exp.size());
        $fatal(1, "watchdog");
    end

    // Monitor: one expected vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            m_act  = {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                      MAR_enable, MDR_enable, r_enable, con_enable, manual_R15_enable,
                      read, write, Gra, Grb, Grc, ba_select,
                      PC_select, Z_LO_select, MDR_select, c_select, r_select,
                      alu_instruction, run, instr_done};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got %07h want %07h", m_name, m_act, m_exp);
            end
        end
    end

    function automatic ctl_t on();
        ctl_t c;
        c = '0;
        c.run = 1'b1;
        return c;
    endfunction

    task automatic push(input string nm, input ctl_t e);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_instr(input logic [31:0] ir, input logic con, input string nm);
        ctl_t e;
        IR_Data    = ir;
        con_output = con;
        e = on(); e.pc_sel = 1'b1; e.mar_en = 1'b1;             push({nm, ".T0"}, e);
        e = on(); e.pc_inc = 1'b1; e.rd = 1'b1; e.mdr_en = 1'b1; push({nm, ".T1"}, e);
        e = on(); e.mdr_sel = 1'b1; e.ir_en = 1'b1;              push({nm, ".T2"}, e);
    endtask

    task automatic wb_z(input string nm);
        ctl_t e;
        e = on(); e.zlo_sel = 1'b1; e.gra = 1'b1; e.r_en = 1'b1; e.done = 1'b1;
        push(nm, e);
    endtask

    task automatic do_rtype(input logic [31:0] ir, input logic [4:0] alu, input string nm);
        ctl_t e;
        begin_instr(ir, 1'b0, nm);
        e = on(); e.grb = 1'b1; e.r_sel = 1'b1; e.y_en = 1'b1;                 push({nm, ".T3"}, e);
        e = on(); e.grc = 1'b1; e.r_sel = 1'b1; e.alu = alu; e.z_en = 1'b1;    push({nm, ".T4"}, e);
        wb_z({nm, ".T5"});
        step(6);
    endtask

    task automatic do_imm(input logic [31:0] ir, input logic is_ldi, input string nm);
        ctl_t e;
        begin_instr(ir, 1'b0, nm);
        e = on(); e.grb = 1'b1; e.y_en = 1'b1;
        if (is_ldi) e.ba = 1'b1; else e.r_sel = 1'b1;
        push({nm, ".T3"}, e);
        e = on(); e.c_sel = 1'b1; e.alu = ALU_ADD; e.z_en = 1'b1;              push({nm, ".T4"}, e);
        wb_z({nm, ".T5"});
        step(6);
    endtask

    task automatic do_mem(input logic [31:0] ir, input logic is_st, input string nm);
        ctl_t e;
        begin_instr(ir, 1'b0, nm);
        e = on(); e.grb = 1'b1; e.ba = 1'b1; e.y_en = 1'b1;                    push({nm, ".T3"}, e);
        e = on(); e.c_sel = 1'b1; e.alu = ALU_ADD; e.z_en = 1'b1;              push({nm, ".T4"}, e);
        e = on(); e.zlo_sel = 1'b1; e.mar_en = 1'b1;                           push({nm, ".T5"}, e);
        if (is_st) begin
            e = on(); e.gra = 1'b1; e.r_sel = 1'b1; e.mdr_en = 1'b1;           push({nm, ".T6"}, e);
            e = on(); e.wr = 1'b1; e.done = 1'b1;                              push({nm, ".T7"}, e);
        end else begin
            e = on(); e.rd = 1'b1; e.mdr_en = 1'b1;                            push({nm, ".T6"}, e);
            e = on(); e.mdr_sel = 1'b1; e.gra = 1'b1; e.r_en = 1'b1; e.done = 1'b1;
            push({nm, ".T7"}, e);
        end
        step(8);
    endtask

    task automatic do_br(input logic con, input string nm);
        ctl_t e;
        begin_instr(32'h98000010, con, nm);
        e = on(); e.gra = 1'b1; e.r_sel = 1'b1; e.con_en = 1'b1;               push({nm, ".T3"}, e);
        e = on(); e.pc_sel = 1'b1; e.y_en = 1'b1;                              push({nm, ".T4"}, e);
        e = on(); e.c_sel = 1'b1; e.alu = ALU_ADD; e.z_en = 1'b1;              push({nm, ".T5"}, e);
        e = on(); e.done = 1'b1;
        if (con) begin
            e.zlo_sel = 1'b1;
            e.pc_en   = 1'b1;
        end
        push({nm, ".T6"}, e);
        step(7);
    endtask

    task automatic do_jr(input logic [31:0] ir, input string nm);
        ctl_t e;
        begin_instr(ir, 1'b0, nm);
        e = on(); e.gra = 1'b1; e.r_sel = 1'b1; e.pc_en = 1'b1; e.done = 1'b1; push({nm, ".T3"}, e);
        step(4);
    endtask

    task automatic do_jal(input logic [31:0] ir, input string nm);
        ctl_t e;
        begin_instr(ir, 1'b0, nm);
        e = on(); e.r15_en = 1'b1; e.pc_sel = 1'b1;                            push({nm, ".T3"}, e);
        e = on(); e.gra = 1'b1; e.r_sel = 1'b1; e.pc_en = 1'b1; e.done = 1'b1; push({nm, ".T4"}, e);
        step(5);
    endtask

    task automatic do_nop(input logic [31:0] ir, input string nm);
        ctl_t e;
        begin_instr(ir, 1'b0, nm);
        e = on(); e.done = 1'b1;                                               push({nm, ".T3"}, e);
        step(4);
    endtask

    initial begin
        ctl_t e;
        reset_n    = 1'b0;
        IR_Data    = '0;
        con_output = 1'b0;

        step(1); push("reset", '0);
        step(1); push("reset", '0);
        step(1); reset_n = 1'b1; push("idle", '0);
        step(1);

        do_imm(32'h09000045, 1'b1, "ldi");
        do_rtype(32'h18918000, ALU_ADD, "add");
        do_rtype(32'h20918000, ALU_SUB, "sub");
        do_rtype(32'h28918000, ALU_AND, "and");
        do_rtype(32'h30918000, ALU_OR,  "or");
        do_imm(32'h60900007, 1'b0, "addi");
        do_mem(32'h00900010, 1'b0, "ld");
        do_mem(32'h10900010, 1'b1, "st");
        do_br(1'b0, "br_nt");
        do_br(1'b1, "br_t");
        do_jr(32'hA0800000, "jr");
        do_jal(32'hAA000000, "jal");
        do_nop(32'hD0000000, "nop");
        do_nop(32'h40000000, "unlisted");

        // Reset asserted in the middle of an add's T4
        begin_instr(32'h18918000, 1'b0, "add_rst");
        e = on(); e.grb = 1'b1; e.r_sel = 1'b1; e.y_en = 1'b1;
        push("add_rst.T3", e);
        step(4);
        reset_n = 1'b0; push("rst_mid_t4", '0);
        step(1);        push("rst_hold", '0);
        step(1);
        reset_n = 1'b1; push("rst_idle", '0);
        step(1);
        do_imm(32'h09000045, 1'b1, "ldi_after_rst");

        // Halt: only run during T3, then everything low regardless of IR_Data
        begin_instr(32'hD8000000, 1'b0, "halt");
        push("halt.T3", on());
        step(4);
        for (int i = 0; i < 22; i++) begin
            push("halted", '0);
            IR_Data    = (i % 2 == 0) ? 32'h18918000 : 32'h98000010;
            con_output = i[0];
            step(1);
        end

        step(1);
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
